// File: rtl/serial_word_transmitter_if.sv
// Handshake and serial-link bundle for the serial word transmitter.
// The master side offers words and watches the serial stream; the
// transmitter itself sits on the slave side.
interface serial_word_transmitter_if #(
   parameter int n     = 32,
   parameter int DIV_W = 8
);
   logic [n-1:0]     data_in;
   logic             dir;
   logic [DIV_W-1:0] div;
   logic             valid;
   logic             ready;
   logic             serial_out;
   logic [1:0]       shift_ctrl;
   logic             busy;
   logic             done;

   modport master (
      output data_in, dir, div, valid,
      input  ready, serial_out, shift_ctrl, busy, done
   );

   modport slave (
      input  data_in, dir, div, valid,
      output ready, serial_out, shift_ctrl, busy, done
   );
endinterface

// File: rtl/serial_word_transmitter.sv
// Parallel-to-serial word transmitter.
// Accepts an n-bit word on a valid/ready handshake and emits it one bit per
// programmable bit period (div+1 clocks). shift_ctrl is the ctrl code of a
// downstream universal shifter, asserted only on the last cycle of each bit
// period, so a shifter fed by serial_out holds the word after n strobes.
module serial_word_transmitter #(
   parameter int n     = 32,
   parameter int DIV_W = 8
) (
   input logic                      clk_i,
   input logic                      rst_ni,
   serial_word_transmitter_if.slave bus
);

   localparam int CW = $clog2(n) + 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_e;

   state_e           state_q;
   logic [n-1:0]     shreg_q;
   logic [CW-1:0]    bitCnt_q;
   logic [DIV_W-1:0] divCnt_q;
   logic [DIV_W-1:0] div_q;
   logic             dir_q;
   logic             serial_q;
   logic             busy_q;
   logic             done_q;
   logic [1:0]       shiftCtrl_q;

   logic [n-1:0]     shreg_d;
   logic [CW-1:0]    bitCnt_d;
   logic [DIV_W-1:0] divCnt_d;
   logic             strobe;
   logic             lastBit;
   logic             nextBit;
   logic             firstBit;

   // Shift toward the outgoing end with zero fill; the next outgoing bit is
   // taken from the shifted value so serial_out can be registered.
   always_comb begin
      shreg_d  = dir_q ? (shreg_q >> 1) : (shreg_q << 1);
      bitCnt_d = bitCnt_q + CW'(1);
      divCnt_d = divCnt_q + DIV_W'(1);
      strobe   = (divCnt_q == div_q);
      lastBit  = (bitCnt_d == CW'(n));
      nextBit  = dir_q ? shreg_d[0] : shreg_d[n-1];
      firstBit = bus.dir ? bus.data_in[0] : bus.data_in[n-1];
   end

   // Control FSM and datapath; every output except ready is computed one
   // cycle ahead so it comes straight from a flop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         bitCnt_q    <= '0;
         divCnt_q    <= '0;
         div_q       <= '0;
         dir_q       <= 1'b0;
         serial_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         shiftCtrl_q <= 2'b00;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.valid) begin
                  state_q     <= SHIFT;
                  shreg_q     <= bus.data_in;
                  dir_q       <= bus.dir;
                  div_q       <= bus.div;
                  bitCnt_q    <= '0;
                  divCnt_q    <= '0;
                  busy_q      <= 1'b1;
                  serial_q    <= firstBit;
                  shiftCtrl_q <= (bus.div == '0) ? {1'b1, bus.dir} : 2'b00;
               end
            end
            SHIFT: begin
               if (strobe) begin
                  shreg_q  <= shreg_d;
                  bitCnt_q <= bitCnt_d;
                  divCnt_q <= '0;
                  if (lastBit) begin
                     state_q     <= DONE;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     serial_q    <= 1'b0;
                     shiftCtrl_q <= 2'b00;
                  end else begin
                     serial_q    <= nextBit;
                     shiftCtrl_q <= (div_q == '0) ? {1'b1, dir_q} : 2'b00;
                  end
               end else begin
                  divCnt_q    <= divCnt_d;
                  shiftCtrl_q <= (divCnt_d == div_q) ? {1'b1, dir_q} : 2'b00;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // ready is decoded from the state and held low while reset is asserted,
   // so a word can be taken on the very first edge after reset release.
   assign bus.ready      = rst_ni && (state_q == IDLE);
   assign bus.serial_out = serial_q;
   assign bus.shift_ctrl = shiftCtrl_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_serial_word_transmitter.sv
// Bench for the serial word transmitter: an 8-bit and a 32-bit instance,
// each followed by a behavioural universal shifter acting as the receiver.
module tb_serial_word_transmitter;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   serial_word_transmitter_if #(.n(8),  .DIV_W(8)) if8 ();
   serial_word_transmitter_if #(.n(32), .DIV_W(8)) if32 ();

   serial_word_transmitter #(.n(8), .DIV_W(8)) dut8 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (if8.slave)
   );

   serial_word_transmitter #(.n(32), .DIV_W(8)) dut32 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (if32.slave)
   );

   logic        sel;
   logic [31:0] tbData;
   logic        tbDir;
   logic [7:0]  tbDiv;
   logic        tbValid;

   assign if8.data_in  = tbData[7:0];
   assign if8.dir      = tbDir;
   assign if8.div      = tbDiv;
   assign if8.valid    = tbValid & ~sel;
   assign if32.data_in = tbData;
   assign if32.dir     = tbDir;
   assign if32.div     = tbDiv;
   assign if32.valid   = tbValid & sel;

   // Receivers: plain universal shifters driven by the transmitter.
   logic [7:0]  rx8;
   logic [31:0] rx32;

   always @(posedge clk) begin
      case (if8.shift_ctrl)
         2'b10:   rx8 <= {rx8[6:0], if8.serial_out};
         2'b11:   rx8 <= {if8.serial_out, rx8[7:1]};
         default: rx8 <= rx8;
      endcase
      case (if32.shift_ctrl)
         2'b10:   rx32 <= {rx32[30:0], if32.serial_out};
         2'b11:   rx32 <= {if32.serial_out, rx32[31:1]};
         default: rx32 <= rx32;
      endcase
   end

   wire        obsSerial = sel ? if32.serial_out : if8.serial_out;
   wire [1:0]  obsCtrl   = sel ? if32.shift_ctrl : if8.shift_ctrl;
   wire        obsBusy   = sel ? if32.busy : if8.busy;
   wire        obsDone   = sel ? if32.done : if8.done;
   wire        obsReady  = sel ? if32.ready : if8.ready;
   wire [31:0] obsRx     = sel ? rx32 : {24'h0, rx8};

   int vectors     = 0;
   int miscompares = 0;
   int waited;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One word transaction, checked every cycle against the bit sequence
   // implied by the word, the direction and the bit period. noisy keeps
   // valid high with random data throughout; abortAt pulls reset in that
   // cycle and checks the asynchronous clear.
   task automatic applyStimulus(input logic [31:0] word, input logic d,
                                input logic [7:0] dv, input bit noisy,
                                input int abortAt, output int waitCycles);
      int w;
      int len;
      int bitIdx;
      int phase;
      int idx;
      logic [31:0] mask;
      w    = sel ? 32 : 8;
      mask = sel ? 32'hFFFF_FFFF : 32'h0000_00FF;
      len  = w * (int'(dv) + 1);
      tbData  = word;
      tbDir   = d;
      tbDiv   = dv;
      tbValid = 1'b1;
      waitCycles = 0;
      #1;
      while (!obsReady && waitCycles < 20) begin
         @(negedge clk);
         #1;
         waitCycles++;
      end
      checkOutput("ready_before_accept", obsReady, 1);
      if (!obsReady) begin
         tbValid = 1'b0;
         return;
      end
      @(posedge clk);
      for (int c = 1; c <= len + 1; c++) begin
         @(negedge clk);
         if (noisy) begin
            tbValid = 1'b1;
            tbData  = $urandom;
            tbDir   = 1'($urandom);
            tbDiv   = 8'($urandom);
         end else begin
            tbValid = 1'b0;
         end
         if (c <= len) begin
            bitIdx = (c - 1) / (int'(dv) + 1);
            phase  = (c - 1) % (int'(dv) + 1);
            idx    = d ? bitIdx : (w - 1 - bitIdx);
            checkOutput("serial_out", obsSerial, word[idx]);
            checkOutput("shift_ctrl", obsCtrl,
                        (phase == int'(dv)) ? {30'h0, 1'b1, d} : 32'h0);
            checkOutput("busy_shift", obsBusy, 1);
            checkOutput("done_shift", obsDone, 0);
            checkOutput("ready_shift", obsReady, 0);
         end else begin
            checkOutput("serial_done", obsSerial, 0);
            checkOutput("ctrl_done", obsCtrl, 0);
            checkOutput("busy_done", obsBusy, 0);
            checkOutput("done_pulse", obsDone, 1);
            checkOutput("ready_done", obsReady, 0);
            checkOutput("receiver_word", obsRx & mask, word & mask);
         end
         if (c == abortAt) begin
            #2 rst_n = 1'b0;
            #1;
            checkOutput("abort_serial", obsSerial, 0);
            checkOutput("abort_ctrl", obsCtrl, 0);
            checkOutput("abort_busy", obsBusy, 0);
            checkOutput("abort_done", obsDone, 0);
            checkOutput("abort_ready", obsReady, 0);
            tbValid = 1'b0;
            return;
         end
      end
      if (!noisy) begin
         @(negedge clk);
         checkOutput("ready_after_done", obsReady, 1);
         checkOutput("done_cleared", obsDone, 0);
      end
   endtask

   // Directed and randomized sequence.
   initial begin
      logic [31:0] rw;
      logic        rd;
      logic [7:0]  rdv;
      sel     = 1'b0;
      rst_n   = 1'b0;
      tbValid = 1'b0;
      tbData  = '0;
      tbDir   = 1'b0;
      tbDiv   = '0;
      repeat (2) begin
         @(negedge clk);
         checkOutput("reset_serial", obsSerial, 0);
         checkOutput("reset_ctrl", obsCtrl, 0);
         checkOutput("reset_busy", obsBusy, 0);
         checkOutput("reset_done", obsDone, 0);
         checkOutput("reset_ready", obsReady, 0);
      end
      rst_n = 1'b1;

      $display("[TB] directed words on 8-bit instance");
      applyStimulus(32'hA5, 1'b0, 8'd0, 1'b0, 0, waited);
      applyStimulus(32'hA5, 1'b1, 8'd2, 1'b0, 0, waited);

      applyStimulus(32'h96, 1'b0, 8'd1, 1'b1, 0, waited);
      applyStimulus(32'h3C, 1'b1, 8'd0, 1'b0, 0, waited);
      checkOutput("accept_first_idle_edge", waited, 1);

      $display("[TB] reset abort mid-word");
      applyStimulus(32'hC3, 1'b0, 8'd1, 1'b0, 7, waited);
      tbData  = 32'h81;
      tbDir   = 1'b0;
      tbDiv   = 8'd1;
      tbValid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("held_reset_ready", obsReady, 0);
         checkOutput("held_reset_busy", obsBusy, 0);
         checkOutput("held_reset_done", obsDone, 0);
      end
      rst_n = 1'b1;
      applyStimulus(32'h81, 1'b0, 8'd1, 1'b0, 0, waited);
      checkOutput("accept_after_release", waited, 0);

      $display("[TB] random words");
      for (int i = 0; i < 8; i++) begin
         rw  = $urandom & 32'hFF;
         rd  = 1'($urandom_range(0, 1));
         rdv = 8'($urandom_range(0, 3));
         applyStimulus(rw, rd, rdv, 1'b0, 0, waited);
      end
      applyStimulus($urandom & 32'hFF, 1'b1, 8'd255, 1'b0, 0, waited);

      $display("[TB] 32-bit instance, maximum bit period");
      sel = 1'b1;
      @(negedge clk);
      applyStimulus(32'hFFFF_0001, 1'b0, 8'd255, 1'b0, 0, waited);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
